// File: rtl/engine_alu_ops_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | engine_alu_ops_scheduler: job sequencer, credit-based kernel issue and   |
// | result FIFO for the ALU-ops kernel.                     Revision: 1.0    |
// +--------------------------------------------------------------------------+

package engine_alu_ops_pkg;
  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_SUB  = 2'd1,
    ALU_ACC  = 2'd2,
    ALU_PASS = 2'd3
  } alu_op_e;

  typedef struct packed {
    alu_op_e     op;
    logic [29:0] imm;
  } ALUOpsConfigurationParameters;

  typedef struct packed {
    logic [31:0] b;
    logic [31:0] a;
  } MemoryPacketData;
endpackage

module engine_alu_ops_scheduler
  import engine_alu_ops_pkg::*;
#(
  parameter int KERNEL_LATENCY = 2,
  parameter int OUT_FIFO_DEPTH = 4,
  parameter int COUNT_W        = 32
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         start_in,
  input  ALUOpsConfigurationParameters config_params_in,
  input  logic [COUNT_W-1:0]           num_packets_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  MemoryPacketData              in_data,
  output logic                         kernel_clear,
  output logic                         kernel_config_params_valid,
  output ALUOpsConfigurationParameters kernel_config_params,
  output logic                         kernel_data_valid,
  output MemoryPacketData              kernel_data,
  input  MemoryPacketData              kernel_result,
  output logic                         out_valid,
  input  logic                         out_ready,
  output MemoryPacketData              out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done
);

  localparam int AW     = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
  localparam int CRED_W = $clog2(KERNEL_LATENCY + OUT_FIFO_DEPTH + 2) + 1;
  localparam logic [AW:0]       C_FIFO_FULL = (AW+1)'(OUT_FIFO_DEPTH);
  localparam logic [CRED_W-1:0] C_CREDITS   = CRED_W'(OUT_FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CONFIG = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e                       state_q, state_d;
  ALUOpsConfigurationParameters cfg_q, cfg_d;
  logic [COUNT_W-1:0]           num_q, num_d;
  logic [COUNT_W-1:0]           issued_q, issued_d;
  logic                         kclear_q, kclear_d;
  logic                         kcfg_vld_q, kcfg_vld_d;
  logic                         kvld_q, kvld_d;
  logic                         klast_q, klast_d;
  MemoryPacketData              kdata_q, kdata_d;
  logic [KERNEL_LATENCY-1:0]    sr_vld_q, sr_vld_d;
  logic [KERNEL_LATENCY-1:0]    sr_last_q, sr_last_d;
  MemoryPacketData              mem_q [OUT_FIFO_DEPTH];
  MemoryPacketData              mem_d [OUT_FIFO_DEPTH];
  logic [OUT_FIFO_DEPTH-1:0]    mlast_q, mlast_d;
  logic [AW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [AW:0]                  cnt_q, cnt_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;

  logic [CRED_W-1:0]            w_inflight;
  logic                         w_room;
  logic                         w_in_ready;
  logic                         w_accept;
  logic                         w_push;
  logic                         w_pop;

  // Every accepted packet not yet in the FIFO holds a credit, so a push never meets a full FIFO.
  always_comb begin
    w_inflight = CRED_W'(kvld_q);
    for (int i = 0; i < KERNEL_LATENCY; i++) begin
      w_inflight = w_inflight + CRED_W'(sr_vld_q[i]);
    end
    w_room     = (w_inflight + CRED_W'(cnt_q)) < C_CREDITS;
    w_in_ready = (state_q == S_RUN) && (issued_q < num_q) && w_room;
    w_accept   = in_valid && w_in_ready;
    w_push     = sr_vld_q[KERNEL_LATENCY-1];
    w_pop      = (cnt_q != '0) && out_ready;
  end

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    num_d     = num_q;
    issued_d  = issued_q;
    kdata_d   = kdata_q;
    kvld_d    = w_accept;
    klast_d   = w_accept && (issued_q == (num_q - COUNT_W'(1)));
    sr_vld_d  = KERNEL_LATENCY'({sr_vld_q, kvld_q});
    sr_last_d = KERNEL_LATENCY'({sr_last_q, klast_q});

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d  = S_CONFIG;
          cfg_d    = config_params_in;
          num_d    = num_packets_in;
          issued_d = '0;
        end
      end
      S_CONFIG: state_d = (num_q == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (issued_q == num_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!kvld_q && (sr_vld_q == '0) && (cnt_q == '0)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (w_accept) begin
      kdata_d  = in_data;
      issued_d = issued_q + COUNT_W'(1);
    end

    kclear_d   = (state_d == S_CONFIG);
    kcfg_vld_d = (state_d == S_CONFIG) || (state_d == S_RUN) || (state_d == S_DRAIN);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // Result FIFO; a push and a pop in the same cycle is legal at any occupancy.
  always_comb begin
    mem_d    = mem_q;
    mlast_d  = mlast_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (w_push) begin
      mem_d[wr_ptr_q]   = kernel_result;
      mlast_d[wr_ptr_q] = sr_last_q[KERNEL_LATENCY-1];
      wr_ptr_d          = wr_ptr_q + AW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({w_push, w_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= S_IDLE;
      cfg_q      <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      kclear_q   <= 1'b0;
      kcfg_vld_q <= 1'b0;
      kvld_q     <= 1'b0;
      klast_q    <= 1'b0;
      kdata_q    <= '0;
      sr_vld_q   <= '0;
      sr_last_q  <= '0;
      for (int i = 0; i < OUT_FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      mlast_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      kclear_q   <= kclear_d;
      kcfg_vld_q <= kcfg_vld_d;
      kvld_q     <= kvld_d;
      klast_q    <= klast_d;
      kdata_q    <= kdata_d;
      sr_vld_q   <= sr_vld_d;
      sr_last_q  <= sr_last_d;
      mem_q      <= mem_d;
      mlast_q    <= mlast_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready                   = w_in_ready;
  assign kernel_clear               = kclear_q;
  assign kernel_config_params_valid = kcfg_vld_q;
  assign kernel_config_params       = cfg_q;
  assign kernel_data_valid          = kvld_q;
  assign kernel_data                = kdata_q;
  assign out_valid                  = (cnt_q != '0);
  assign out_data                   = mem_q[rd_ptr_q];
  assign out_last                   = mlast_q[rd_ptr_q];
  assign busy                       = busy_q;
  assign done                       = done_q;

  a_push_never_overflows: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    !(w_push && !w_pop && (cnt_q == C_FIFO_FULL)));

endmodule
`default_nettype wire
